// File: rtl/register_pipe.sv
// register_pipe: elastic pipeline register with a valid/ready handshake per stage.
//
// A chain of STAGES registers, each WIDTH bits wide. An empty stage accepts new
// data even when the stage after it is stalled, so bubbles collapse and the pipe
// holds up to STAGES words under back-pressure. A full pipe with out_ready=1
// accepts and emits in the same cycle through the combinational ready chain.
//
// Parameters:
//   WIDTH   data width in bits (>= 1)
//   STAGES  number of register stages (>= 1)
//   INIT    value loaded into every data register on reset and on flush
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset; highest priority
//   ce         global enable; low freezes the pipe and blocks both handshakes
//   flush      synchronous clear of all stages; priority over ce and handshakes
//   in_data    upstream data
//   in_valid   upstream data valid
//   in_ready   block can accept this cycle
//   out_data   data held in the last stage (always driven)
//   out_valid  last stage holds valid data
//   out_ready  downstream accepts
//   occ        number of occupied stages (only with REGISTER_PIPE_OCC_COUNT_EN)
//
// Optional feature: define REGISTER_PIPE_OCC_COUNT_EN to add the registered
// occupancy output occ.

module register_pipe #(
    parameter int unsigned      WIDTH  = 32,
    parameter int unsigned      STAGES = 2,
    parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef REGISTER_PIPE_OCC_COUNT_EN
    ,
    output logic [$clog2(STAGES+1)-1:0] occ
`endif
);

    logic [STAGES-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]  dat_q [STAGES];
    logic [WIDTH-1:0]  dat_d [STAGES];

    // rdy[i]: stage i may load this cycle (it is empty or its word moves on).
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] src_vld;
    logic [WIDTH-1:0]  src_dat [STAGES];
    logic              run;

    assign run = ce & ~flush;

    // Ready ripples back from the output; a running local avoids reading rdy
    // inside the block that writes it.
    always_comb begin
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            r      = ~vld_q[i] | r;
            rdy[i] = r;
        end
    end

    // Input of each stage: the upstream port for stage 0, the previous stage otherwise.
    always_comb begin
        src_vld    = '0;
        src_vld[0] = in_valid;
        src_dat[0] = in_data;
        for (int i = 1; i < int'(STAGES); i++) begin
            src_vld[i] = vld_q[i-1];
            src_dat[i] = dat_q[i-1];
        end
    end

    // Bubbles propagate as valid=0 but never overwrite stored data.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        for (int i = 0; i < int'(STAGES); i++) begin
            if (rdy[i]) begin
                vld_d[i] = src_vld[i];
                if (src_vld[i]) begin
                    dat_d[i] = src_dat[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                dat_q[i] <= INIT;
            end
        end else if (ce) begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign in_ready  = rdy[0] & run;
    assign out_valid = vld_q[STAGES-1] & run;
    assign out_data  = dat_q[STAGES-1];

`ifdef REGISTER_PIPE_OCC_COUNT_EN
    localparam int unsigned OccW = $clog2(STAGES + 1);

    logic [OccW-1:0] occ_q;
    logic            in_fire;
    logic            out_fire;

    // Internal stage-to-stage moves conserve the word count, so only the two
    // port transfers change occupancy.
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_q <= '0;
        end else if (in_fire && !out_fire) begin
            occ_q <= occ_q + OccW'(1);
        end else if (!in_fire && out_fire) begin
            occ_q <= occ_q - OccW'(1);
        end
    end

    assign occ = occ_q;
`endif

endmodule

// File: tb/tb_register_pipe.sv
// Self-checking bench for register_pipe (WIDTH=8, STAGES=3, INIT=8'h5A).
// A reference model tracks each word in flight as (data, stage position) and
// moves words forward by occupancy rules; directed scenarios are followed by a
// randomized run.

module tb_register_pipe;

    localparam int unsigned   W      = 8;
    localparam int unsigned   S      = 3;
    localparam logic [W-1:0]  INIT_V = 8'h5A;

    logic         clk = 1'b0;
    logic         rst, ce, flush;
    logic [W-1:0] in_data;
    logic         in_valid, in_ready;
    logic [W-1:0] out_data;
    logic         out_valid, out_ready;
`ifdef REGISTER_PIPE_OCC_COUNT_EN
    logic [1:0]   occ;
`endif

    register_pipe #(
        .WIDTH  (W),
        .STAGES (S),
        .INIT   (INIT_V)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef REGISTER_PIPE_OCC_COUNT_EN
        ,
        .occ       (occ)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           pos;
    } word_t;

    word_t        q[$];          // oldest word first
    logic [W-1:0] last_dat;      // value currently held by the last data register
    logic [W-1:0] got[$];        // words observed leaving through the output port
    logic [W-1:0] e[$];
    int           checks = 0;
    int           errors = 0;

    logic         s_in_ready, s_out_valid;
    logic [W-1:0] s_out_data;
    logic [1:0]   s_occ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs against
    // the model, then advance the model across the rising edge.
    task automatic step(input logic iv, input logic [W-1:0] id, input logic orr,
                        input logic c, input logic fl, input logic r);
        bit    adv [S];
        int    n;
        logic  exp_ir, exp_ov;
        word_t w;
        word_t nq[$];

        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = orr;
        ce        = c;
        flush     = fl;
        rst       = r;
        #1;

        // A word moves on if the slot ahead is free or the word ahead also moves;
        // the oldest word moves unless it sits at the output with out_ready low.
        n = q.size();
        for (int k = 0; k < n; k++) begin
            if (k == 0) adv[k] = !(q[0].pos == int'(S) - 1 && !orr);
            else        adv[k] = (q[k].pos + 1 < q[k-1].pos) || adv[k-1];
        end
        exp_ir = c && !fl && (n == 0 || q[n-1].pos != 0 || adv[n-1]);
        exp_ov = c && !fl && n > 0 && q[0].pos == int'(S) - 1;

        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out_data  = out_data;
`ifdef REGISTER_PIPE_OCC_COUNT_EN
        s_occ       = occ;
        chk("occ", 32'(occ), n);
`else
        s_occ       = 2'(n);
`endif
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("out_data", 32'(out_data), 32'(last_dat));
        if (out_valid && orr) got.push_back(out_data);

        @(posedge clk);
        if (r || fl) begin
            q.delete();
            last_dat = INIT_V;
        end else if (c) begin
            for (int k = 0; k < n; k++) begin
                if (!adv[k]) begin
                    nq.push_back(q[k]);
                end else if (q[k].pos != int'(S) - 1) begin
                    w     = q[k];
                    w.pos = w.pos + 1;
                    if (w.pos == int'(S) - 1) last_dat = w.d;
                    nq.push_back(w);
                end
            end
            if (iv && exp_ir) begin
                w.d   = id;
                w.pos = 0;
                if (int'(S) == 1) last_dat = id;
                nq.push_back(w);
            end
            q = nq;
        end
    endtask

    task automatic check_got(input string tag, input logic [W-1:0] exp_q[$]);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("%s_word%0d", tag, k), 32'(got[k]), 32'(exp_q[k]));
        end
        got.delete();
    endtask

    initial begin
        logic         pv;
        logic [W-1:0] pd;
        logic         orr, c, fl, r;

        rst = 1'b1; ce = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        q.delete();
        last_dat = INIT_V;

        // Reset state
        step(0, 8'h00, 1, 1, 0, 0);
        chk("reset_out_valid", 32'(s_out_valid), 0);
        chk("reset_out_data", 32'(s_out_data), 32'(INIT_V));
        chk("reset_in_ready", 32'(s_in_ready), 1);

        // Stream: three words back to back, out_ready high
        got.delete();
        step(1, 8'h11, 1, 1, 0, 0); chk("stream_ir0", 32'(s_in_ready), 1);
        step(1, 8'h22, 1, 1, 0, 0); chk("stream_ir1", 32'(s_in_ready), 1);
        step(1, 8'h33, 1, 1, 0, 0); chk("stream_ir2", 32'(s_in_ready), 1);
        chk("stream_not_yet", 32'(s_out_valid), 0);
        step(0, 8'h00, 1, 1, 0, 0);
        chk("stream_first_out", 32'(s_out_valid), 1);
        repeat (4) step(0, 8'h00, 1, 1, 0, 0);
        e = '{8'h11, 8'h22, 8'h33};
        check_got("stream", e);

        // Back-pressure fill
        step(1, 8'hA1, 0, 1, 0, 0);
        step(1, 8'hA2, 0, 1, 0, 0);
        step(1, 8'hA3, 0, 1, 0, 0);
        step(1, 8'hA4, 0, 1, 0, 0);
        chk("full_in_ready", 32'(s_in_ready), 0);
        step(1, 8'hA4, 1, 1, 0, 0);
        chk("full_pass_ir", 32'(s_in_ready), 1);
        chk("full_pass_out", 32'(s_out_data), 32'(8'hA1));
        repeat (4) step(0, 8'h00, 1, 1, 0, 0);
        e = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        check_got("backpressure", e);

        // Bubble collapse under a stalled output
        step(1, 8'h05, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        step(1, 8'h06, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
`ifdef REGISTER_PIPE_OCC_COUNT_EN
        chk("bubble_occ", 32'(s_occ), 2);
`endif
        chk("bubble_ir", 32'(s_in_ready), 1);
        repeat (4) step(0, 8'h00, 1, 1, 0, 0);
        e = '{8'h05, 8'h06};
        check_got("bubble", e);

        // Global stall with two words in flight
        step(1, 8'h77, 1, 1, 0, 0);
        step(1, 8'h88, 1, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 8'h99, 1, 0, 0, 0);
            chk("stall_ir", 32'(s_in_ready), 0);
            chk("stall_ov", 32'(s_out_valid), 0);
        end
        repeat (5) step(0, 8'h00, 1, 1, 0, 0);
        e = '{8'h77, 8'h88};
        check_got("stall", e);

        // Flush with a word offered
        step(1, 8'hB1, 0, 1, 0, 0);
        step(1, 8'hB2, 0, 1, 0, 0);
        step(1, 8'hB3, 0, 1, 0, 0);
        step(1, 8'hEE, 0, 1, 1, 0);
        chk("flush_ir", 32'(s_in_ready), 0);
        chk("flush_ov", 32'(s_out_valid), 0);
        step(0, 8'h00, 1, 1, 0, 0);
        chk("flush_after_ov", 32'(s_out_valid), 0);
        chk("flush_after_od", 32'(s_out_data), 32'(INIT_V));
        chk("flush_after_ir", 32'(s_in_ready), 1);
        repeat (3) step(0, 8'h00, 1, 1, 0, 0);
        e.delete();
        check_got("flush", e);

        // Same sequence with reset mid-stream
        step(1, 8'hC1, 0, 1, 0, 0);
        step(1, 8'hC2, 0, 1, 0, 0);
        step(1, 8'hC3, 0, 1, 0, 0);
        step(1, 8'hEE, 0, 1, 0, 1);
        step(0, 8'h00, 1, 1, 0, 0);
        chk("rst_after_ov", 32'(s_out_valid), 0);
        chk("rst_after_od", 32'(s_out_data), 32'(INIT_V));
        chk("rst_after_ir", 32'(s_in_ready), 1);
        repeat (3) step(0, 8'h00, 1, 1, 0, 0);
        e.delete();
        check_got("rst", e);

        // Randomized traffic; an offered word is held until accepted
        pv = 1'b0;
        pd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 99) < 60);
                pd = W'($urandom);
            end
            orr = ($urandom_range(0, 99) < 60);
            c   = ($urandom_range(0, 99) < 88);
            fl  = ($urandom_range(0, 99) < 2);
            r   = ($urandom_range(0, 199) < 1);
            step(pv, pd, orr, c, fl, r);
            if ((pv && s_in_ready) || fl || r) pv = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_pipe.md
Name: register_pipe

Overview:
- Parametrised elastic pipeline register: a chain of STAGES registers, each WIDTH bits wide, with a valid/ready handshake on every stage.
- Generalises the plain D-register, clock-enable and reset-value registers into one block, adding back-pressure, bubble collapsing, flush and global stall.
- Used between CPU datapath stages (fetch/decode/execute) and on bus paths that need registered, stallable transfer.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- STAGES, 2, number of register stages (>=1).
- INIT, {WIDTH{1'b0}}, value loaded into every data register on reset and on flush.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- ce  input  1  global clock enable; low freezes the entire pipeline.
- flush  input  1  synchronous clear of all stages; priority over ce and the handshakes.
- in_data  input  WIDTH  upstream data.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  data held in the last stage.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts.

Behaviour:
- State per stage i (0..STAGES-1): vld[i] (1 bit) and dat[i] (WIDTH bits). Stage 0 is the input side; stage STAGES-1 drives the outputs.
- Reset (rst=1 at a clock edge): all vld=0, all dat=INIT. Outputs after reset: out_valid=0, out_data=INIT, in_ready=ce & ~flush. rst has priority over everything, including mid-transfer; any in-flight data is discarded.
- Combinational ready chain:
  - rdy[STAGES] = out_ready.
  - rdy[i] = ~vld[i] | rdy[i+1].
  - in_ready = rdy[0] & ce & ~flush.
  - out_valid = vld[STAGES-1] & ce & ~flush.
  - out_data = dat[STAGES-1], always driven, even when not valid.
- Per-stage update when ce=1, flush=0, rst=0. The input to stage i is stage i-1, or in_valid/in_data for i=0.
  - If rdy[i]=1: vld[i] <= input valid.
  - If rdy[i]=1 and the input is valid: dat[i] <= input data.
  - If rdy[i]=0: the stage holds.
  - Data registers are not written by a bubble; dat keeps its old value when the incoming valid is 0.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_valid may be asserted before in_ready; in_data must stay stable until the transfer.
- Latency and throughput: with out_ready held high and the pipe empty, a word accepted at edge N appears on out_data with out_valid=1 after edge N+STAGES-1 (STAGES-cycle latency). Throughput is one word per cycle.
- Bubble collapse: an empty stage accepts even while downstream is stalled. The pipe therefore holds up to STAGES words under back-pressure.
- Full: all vld=1 and out_ready=0 gives in_ready=0.
- Full with out_ready=1: in_ready=1 in the same cycle (combinational pass-through). Accept and emit happen simultaneously; occupancy is unchanged.
- ce=0: no register changes; in_ready=0 and out_valid=0, so no handshake can occur. Stored contents are preserved and reappear when ce returns to 1.
- flush=1 (rst=0): all vld <= 0, all dat <= INIT, regardless of ce. in_ready=0 and out_valid=0 that cycle; the word on in_data is not accepted.
- STAGES=1: degenerates to a single skid-free register with a handshake.

Optional Feature:
- Macro: REGISTER_PIPE_OCC_COUNT_EN.
- When defined, adds the port occ (output, width $clog2(STAGES+1)) giving the number of stages with vld=1.
  - occ is registered.
  - It is 0 after reset and after flush, and never exceeds STAGES.
  - It changes by +1, -1 or 0 per cycle according to the input/output transfers.
- When not defined, the port and its counter are absent; all other behaviour is identical.

Test Plan (WIDTH=8, STAGES=3, INIT=8'h00 unless stated):
- Stream: after reset, ce=1, out_ready=1; drive 8'h11, 8'h22, 8'h33 on consecutive cycles with in_valid=1 -> out_valid rises 3 cycles after the first accept; out_data reads 11, 22, 33 on consecutive cycles; in_ready stays 1 throughout.
- Back-pressure fill: out_ready=0; offer 8'hA1, A2, A3, A4 -> A1..A3 accepted, in_ready=0 while A4 is offered; release out_ready=1 -> outputs A1, A2, A3, A4 in order, with A4 accepted in the same cycle A1 leaves.
- Bubble collapse: accept 8'h05, idle 2 cycles, accept 8'h06, with out_ready=0 -> both words held (occ=2 when the macro is defined); output order 05 then 06 once out_ready=1.
- Stall: with 2 words in flight, hold ce=0 for 4 cycles while in_valid=1 and out_ready=1 -> no accepts, out_valid=0, contents intact; after ce=1 they drain unchanged.
- Flush vs reset: with INIT=8'h5A, fill 3 words then assert flush for 1 cycle alongside in_valid=1 -> next cycle out_valid=0, out_data=8'h5A, in_ready=1, offered word dropped; repeat using rst mid-stream -> identical result.
